oclib_csr_reg_target: RTL and testbench

Single-space CSR endpoint that terminates one output of the CSR space splitter: it accepts the splitter's broadcast CSR request plus that space's select bit, decodes word addresses into a bank of 32-bit registers, and returns a registered feedback response. It is the leaf stage every space of a splitter is expected to connect to. Registers are individually read/write or read-only, the latter reflecting live hardware status.

---
 rtl/oclib_pkg.sv | 18 +
 rtl/oclib_csr_reg_target_if.sv | 11 +
 rtl/oclib_csr_reg_target.sv | 115 +++++++++++
 tb/tb_oclib_csr_reg_target.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared CSR bus types used by the splitter and every CSR endpoint.
package oclib_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  space;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

endpackage

// File: rtl/oclib_csr_reg_target_if.sv
// CSR request/feedback bundle for one splitter space, with master and slave views.
interface oclib_csr_reg_target_if;
  import oclib_pkg::*;

  logic       csrSelect;
  csr_32_s    req;
  csr_32_fb_s fb;

  modport master (output csrSelect, output req, input  fb);
  modport slave  (input  csrSelect, input  req, output fb);
endinterface

// File: rtl/oclib_csr_reg_target.sv
// Leaf CSR endpoint: decodes word addresses into a bank of 32-bit registers
// and answers each held request with exactly one registered ready pulse.
module oclib_csr_reg_target
  import oclib_pkg::*;
#(
  parameter type                 CsrType      = csr_32_s,
  parameter type                 CsrFbType    = csr_32_fb_s,
  parameter int                  RegCount     = 8,
  parameter logic [RegCount-1:0] ReadOnlyMask = '0,
  parameter logic [31:0]         ResetValue   = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     csrSelect,
  input  CsrType                   in,
  output CsrFbType                 inFb,
  output logic [RegCount-1:0][31:0] regOut,
  input  logic [RegCount-1:0][31:0] regIn,
  output logic [RegCount-1:0]      writePulse
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESPOND,
    ST_RELEASE
  } state_e;

  state_e              state;
  logic                req_valid;
  logic [29:0]         idx;
  logic [RegCount-1:0] hit;
  logic                ro_hit;
  logic [31:0]         rd_val;
  logic                err;
  logic [RegCount-1:0] wr_en;
  logic                unused_space;

  assign unused_space = ^in.space;

  // NOTE: every variable gets a default before any conditional assignment,
  // otherwise synthesis infers a latch to hold the unassigned value.
  always_comb begin
    req_valid = csrSelect & (in.read | in.write);
    idx       = in.address[31:2];
    hit       = '0;
    ro_hit    = 1'b0;
    rd_val    = '0;
    for (int i = 0; i < RegCount; i++) begin
      if (idx == 30'(i)) begin
        hit[i] = 1'b1;
        ro_hit = ReadOnlyMask[i];
        rd_val = ReadOnlyMask[i] ? regIn[i] : regOut[i];
      end
    end
    // An index with no matching register is out of range.
    err   = (in.address[1:0] != 2'b00) | ~(|hit) | (in.read & in.write)
          | (in.write & ro_hit);
    wr_en = (state == ST_IDLE && req_valid && in.write && !err) ? hit : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      inFb       <= '0;
      writePulse <= '0;
    end else begin
      writePulse <= wr_en;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state       <= ST_RESPOND;
            inFb.ready  <= 1'b1;
            inFb.error  <= err;
            inFb.rdata  <= (in.read && !err) ? rd_val : '0;
          end
        end
        ST_RESPOND: begin
          // Ready is committed here even if csrSelect has already dropped.
          state <= ST_RELEASE;
          inFb  <= '0;
        end
        ST_RELEASE: begin
          if (!csrSelect || !(in.read || in.write)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the register bank is a handful of flops, not a RAM, so each
  // entry takes the reset value directly.
  for (genvar i = 0; i < RegCount; i++) begin : g_reg
    logic [31:0] value;

    if (ReadOnlyMask[i]) begin : g_ro
      always_ff @(posedge clock or posedge reset) begin
        if (reset) value <= ResetValue;
        else       value <= regIn[i];
      end
    end else begin : g_rw
      logic unused_reg_in;
      assign unused_reg_in = ^regIn[i];

      always_ff @(posedge clock or posedge reset) begin
        if (reset)         value <= ResetValue;
        else if (wr_en[i]) value <= in.wdata;
      end
    end

    assign regOut[i] = value;
  end

endmodule

// File: tb/tb_oclib_csr_reg_target.sv
// Self-checking bench for oclib_csr_reg_target: directed protocol cases plus
// randomized accesses checked against an array-based register model.
module tb_oclib_csr_reg_target;
  import oclib_pkg::*;

  localparam int              N  = 8;
  localparam logic [N-1:0]    RO = 8'b0000_1000;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N-1:0][31:0]    reg_out;
  logic [N-1:0][31:0]    reg_in;
  logic [N-1:0]          write_pulse;

  oclib_csr_reg_target_if bus ();

  oclib_csr_reg_target #(
    .RegCount    (N),
    .ReadOnlyMask(RO),
    .ResetValue  (32'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .csrSelect (bus.csrSelect),
    .in        (bus.req),
    .inFb      (bus.fb),
    .regOut    (reg_out),
    .regIn     (reg_in),
    .writePulse(write_pulse)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [N];

  // Reference decode: what the spec says the answer to one access must be.
  function automatic logic model_err(input logic rd, input logic wr,
                                     input logic [31:0] addr);
    logic [31:0] index;
    index = addr >> 2;
    if (addr[1:0] != 2'b00) return 1'b1;
    if (index >= N)         return 1'b1;
    if (rd && wr)           return 1'b1;
    if (wr && RO[index])    return 1'b1;
    return 1'b0;
  endfunction

  // Drives one request, drops it on ready, observes 6 cycles in total.
  task automatic csr_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic err,
                            output int lat, output logic [N-1:0] pulses,
                            output int pulse_cnt, output int ready_cnt);
    @(negedge clock);
    bus.csrSelect    = 1'b1;
    bus.req.read     = rd;
    bus.req.write    = wr;
    bus.req.address  = addr;
    bus.req.wdata    = data;
    lat = -1; pulses = '0; pulse_cnt = 0; ready_cnt = 0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      pulses    |= write_pulse;
      pulse_cnt += $countones(write_pulse);
      if (bus.fb.ready) begin
        ready_cnt++;
        if (lat < 0) begin
          lat   = c;
          rdata = bus.fb.rdata;
          err   = bus.fb.error;
          bus.req.read  = 1'b0;
          bus.req.write = 1'b0;
        end
      end
    end
    bus.req.read  = 1'b0;
    bus.req.write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.fb !== '0) begin
      errors++; $display("FAIL reset_fb got %h want 0", bus.fb);
    end
    checks++;
    if (write_pulse !== '0) begin
      errors++; $display("FAIL reset_pulse got %b want 0", write_pulse);
    end
    checks++;
    if (reg_out !== '0) begin
      errors++; $display("FAIL reset_regs got %h want 0", reg_out);
    end
    reset = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 32'h0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    logic [31:0] rdata; logic err; int lat, pc, rc; logic [N-1:0] pulses;
    csr_access(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, rdata, err, lat, pulses, pc, rc);
    model[2] = 32'hDEADBEEF;
    checks++;
    if (lat !== 1 || rc !== 1 || err !== 1'b0) begin
      errors++; $display("FAIL wr_resp lat=%0d readies=%0d err=%b want 1/1/0", lat, rc, err);
    end
    checks++;
    if (pulses !== 8'b0000_0100 || pc !== 1) begin
      errors++; $display("FAIL wr_pulse got %b x%0d want 00000100 x1", pulses, pc);
    end
    checks++;
    if (reg_out[2] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_regout got %h want deadbeef", reg_out[2]);
    end
    csr_access(1'b1, 1'b0, 32'h8, 32'h0, rdata, err, lat, pulses, pc, rc);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rdata !== 32'hDEADBEEF || pc !== 0) begin
      errors++; $display("FAIL rd_back got lat=%0d err=%b rdata=%h want 1/0/deadbeef", lat, err, rdata);
    end
  endtask

  task automatic test_read_only();
    logic [31:0] rdata; logic err; int lat, pc, rc; logic [N-1:0] pulses;
    csr_access(1'b1, 1'b0, 32'hC, 32'h0, rdata, err, lat, pulses, pc, rc);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rdata !== 32'h1234) begin
      errors++; $display("FAIL ro_read got lat=%0d err=%b rdata=%h want 1/0/1234", lat, err, rdata);
    end
    csr_access(1'b0, 1'b1, 32'hC, 32'hFFFF_FFFF, rdata, err, lat, pulses, pc, rc);
    checks++;
    if (lat !== 1 || err !== 1'b1 || pc !== 0 || reg_out[3] !== 32'h1234) begin
      errors++; $display("FAIL ro_write got lat=%0d err=%b pulses=%0d reg=%h want 1/1/0/1234",
                         lat, err, pc, reg_out[3]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rdata; logic err; int lat, pc, rc; logic [N-1:0] pulses;
    logic        rd_t   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        wr_t   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] addr_t [4] = '{32'h5, 32'h20, 32'h4, 32'h20};
    for (int k = 0; k < 4; k++) begin
      csr_access(rd_t[k], wr_t[k], addr_t[k], 32'hA5A5_5A5A, rdata, err, lat, pulses, pc, rc);
      checks++;
      if (lat !== 1 || err !== 1'b1 || rdata !== 32'h0 || pc !== 0 || reg_out[1] !== model[1]) begin
        errors++; $display("FAIL err_case%0d got lat=%0d err=%b rdata=%h pulses=%0d want 1/1/0/0",
                           k, lat, err, rdata, pc);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rdata, addr, data, exp_rdata, index; logic err, rd, wr, exp_err;
    int lat, pc, rc, kind, pick; logic [N-1:0] pulses, exp_pulses;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        reg_in[3] = $urandom();
        @(negedge clock);
      end
      pick = $urandom_range(0, 11);
      if (pick < N) addr = 32'(pick) << 2;
      else if (pick < 10) begin
        addr = $urandom(); addr[1:0] = 2'b00;
        if ((addr >> 2) < N) addr[31] = 1'b1;
      end else addr = (32'($urandom_range(0, N - 1)) << 2) | 32'($urandom_range(1, 3));
      kind = $urandom_range(0, 4);
      rd   = (kind <= 1) || (kind == 4);
      wr   = (kind >= 2);
      data = $urandom();
      index      = addr >> 2;
      exp_err    = model_err(rd, wr, addr);
      exp_rdata  = (rd && !exp_err) ? (RO[index] ? reg_in[index] : model[index]) : 32'h0;
      exp_pulses = '0;
      if (wr && !exp_err) begin
        model[index]      = data;
        exp_pulses[index] = 1'b1;
      end
      csr_access(rd, wr, addr, data, rdata, err, lat, pulses, pc, rc);
      checks++;
      if (lat !== 1 || rc !== 1 || err !== exp_err || (rd && rdata !== exp_rdata)
          || pulses !== exp_pulses || pc !== $countones(exp_pulses)) begin
        errors++; $display("FAIL rand%0d a=%h rd=%b wr=%b got lat=%0d err=%b rdata=%h pul=%b want err=%b rdata=%h pul=%b",
                           it, addr, rd, wr, lat, err, rdata, pulses, exp_err, exp_rdata, exp_pulses);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (reg_out[i] !== (RO[i] ? reg_in[i] : model[i])) begin
          errors++; $display("FAIL rand%0d regOut[%0d] got %h want %h",
                             it, i, reg_out[i], RO[i] ? reg_in[i] : model[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] data, rdata; logic err; int lat, pc, rc, readies, pulses_seen, after;
    logic [N-1:0] pulses;
    data = $urandom();
    @(negedge clock);
    bus.csrSelect = 1'b1; bus.req.read = 1'b0; bus.req.write = 1'b1;
    bus.req.address = 32'h14; bus.req.wdata = data;
    readies = 0; pulses_seen = 0; after = -1;
    for (int c = 0; c < 12 && after < 6; c++) begin
      @(negedge clock);
      readies     += int'(bus.fb.ready);
      pulses_seen += $countones(write_pulse);
      if (bus.fb.ready && after < 0) after = 0;
      else if (after >= 0) after++;
      if (after == 1) bus.req.wdata = ~data;
    end
    bus.req.write = 1'b0;
    model[5] = data;
    checks++;
    if (readies !== 1 || pulses_seen !== 1 || reg_out[5] !== data) begin
      errors++; $display("FAIL hold got readies=%0d pulses=%0d reg=%h want 1/1/%h",
                         readies, pulses_seen, reg_out[5], data);
    end
    csr_access(1'b1, 1'b0, 32'h14, 32'h0, rdata, err, lat, pulses, pc, rc);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rdata !== data) begin
      errors++; $display("FAIL hold_next got lat=%0d err=%b rdata=%h want 1/0/%h", lat, err, rdata, data);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] data; int readies, pulses_seen;
    data = $urandom() | 32'h1;
    @(negedge clock);
    bus.csrSelect = 1'b1; bus.req.read = 1'b0; bus.req.write = 1'b1;
    bus.req.address = 32'h18; bus.req.wdata = data;
    @(negedge clock);
    checks++;
    if (bus.fb.ready !== 1'b1 || reg_out[6] !== data) begin
      errors++; $display("FAIL rst_pre got ready=%b reg=%h want 1/%h", bus.fb.ready, reg_out[6], data);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) model[i] = 32'h0;
    checks++;
    if (bus.fb.ready !== 1'b0 || reg_out !== '0) begin
      errors++; $display("FAIL rst_mid got ready=%b regs=%h want 0/0", bus.fb.ready, reg_out);
    end
    @(negedge clock);
    reset = 1'b0;
    readies = 0; pulses_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      pulses_seen += $countones(write_pulse);
      if (bus.fb.ready) begin
        readies++;
        bus.req.write = 1'b0;
      end
    end
    bus.req.write = 1'b0;
    model[6] = data;
    checks++;
    if (readies !== 1 || pulses_seen !== 1 || reg_out[6] !== data || reg_out[2] !== 32'h0) begin
      errors++; $display("FAIL rst_post got readies=%0d pulses=%0d reg6=%h reg2=%h want 1/1/%h/0",
                         readies, pulses_seen, reg_out[6], reg_out[2], data);
    end
  endtask

  task automatic test_no_select();
    logic [31:0] rdata; logic err; int lat, pc, rc, readies, pulses_seen;
    logic [N-1:0] pulses;
    @(negedge clock);
    bus.csrSelect = 1'b0; bus.req.read = 1'b0; bus.req.write = 1'b1;
    bus.req.address = 32'h4; bus.req.wdata = 32'hCAFE_F00D;
    readies = 0; pulses_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      readies     += int'(bus.fb.ready);
      pulses_seen += $countones(write_pulse);
    end
    bus.req.write = 1'b0;
    checks++;
    if (readies !== 0 || pulses_seen !== 0 || reg_out[1] !== model[1]) begin
      errors++; $display("FAIL nosel got readies=%0d pulses=%0d reg=%h want 0/0/%h",
                         readies, pulses_seen, reg_out[1], model[1]);
    end
    csr_access(1'b1, 1'b0, 32'h18, 32'h0, rdata, err, lat, pulses, pc, rc);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rdata !== model[6]) begin
      errors++; $display("FAIL nosel_after got lat=%0d err=%b rdata=%h want 1/0/%h", lat, err, rdata, model[6]);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.csrSelect   = 1'b0;
    bus.req         = '0;
    reg_in          = '0;
    for (int i = 0; i < N; i++) reg_in[i] = $urandom();
    reg_in[3]       = 32'h1234;
    test_reset();
    test_write_read();
    test_read_only();
    test_errors();
    test_hold();
    test_reset_mid();
    test_no_select();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
